// File: rtl/interconnect_link_fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : interconnect_link_fifo_pkg
//  Purpose  : Shared interconnect header. Holds the tag/word widths used on
//             every inter-router link, the link bundle type, the packed
//             storage entry used by the link FIFO and the default FIFO depth.
//  Contents : TIA_TAG_WIDTH, TIA_WORD_WIDTH, TIA_INTERCONNECT_FIFO_DEPTH,
//             interconnect_link_t, interconnect_entry_t
//  Revision : 1.0  initial release
// ============================================================================
package interconnect_link_fifo_pkg;

    // Width of the tag that travels with each word across a link.
    localparam int TIA_TAG_WIDTH  = 3;

    // Width of the data word carried on a link.
    localparam int TIA_WORD_WIDTH = 32;

    // Default number of entries in each link elastic buffer.
    localparam int TIA_INTERCONNECT_FIFO_DEPTH = 4;

    // One direction of a link as seen between a splitter and a combiner.
    typedef struct packed {
        logic                      valid;
        logic [TIA_TAG_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } interconnect_link_t;

    // One buffered word: tag and data are stored and moved as a unit so
    // they can never be separated inside the FIFO.
    typedef struct packed {
        logic [TIA_TAG_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } interconnect_entry_t;

endpackage : interconnect_link_fifo_pkg
`default_nettype wire

// File: rtl/interconnect_link_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : interconnect_link_fifo
//  Purpose  : First-word-fall-through elastic buffer placed on each
//             inter-router link. Breaks the combinational handshake chain
//             between neighbouring routers and reports quiescence.
//  Ports    : clock         - rising-edge clock
//             reset         - asynchronous, active-low reset
//             enable        - gates both handshakes when low
//             quiescent     - FIFO holds no entries
//             input_valid   - upstream offers a word
//             input_tag     - tag of the offered word
//             input_data    - data of the offered word
//             input_ready   - FIFO accepts the offered word this cycle
//             output_valid  - head entry is available
//             output_tag    - tag of the head entry
//             output_data   - data of the head entry
//             output_ready  - downstream consumes the head entry
//  Revision : 1.0  initial release
// ============================================================================
module interconnect_link_fifo
    import interconnect_link_fifo_pkg::*;
#(
    parameter int DEPTH      = TIA_INTERCONNECT_FIFO_DEPTH,
    parameter int TAG_WIDTH  = TIA_TAG_WIDTH,
    parameter int WORD_WIDTH = TIA_WORD_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  quiescent,

    input  logic                  input_valid,
    input  logic [TAG_WIDTH-1:0]  input_tag,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic                  input_ready,

    output logic                  output_valid,
    output logic [TAG_WIDTH-1:0]  output_tag,
    output logic [WORD_WIDTH-1:0] output_data,
    input  logic                  output_ready
);

    // Pointers wrap naturally because DEPTH is a power of two. The count
    // carries one extra bit so that "full" (DEPTH) differs from "empty" (0).
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter guards
    // ------------------------------------------------------------------
    // Storage uses the shared entry type, so the port widths must agree
    // with the interconnect header.
    if (TAG_WIDTH != TIA_TAG_WIDTH || WORD_WIDTH != TIA_WORD_WIDTH) begin : g_bad_width
        $error("interconnect_link_fifo: TAG_WIDTH/WORD_WIDTH must match the interconnect header");
    end

    // Natural pointer wrap only works for power-of-two depths.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("interconnect_link_fifo: DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    interconnect_entry_t storage [DEPTH];

    logic                not_full;
    logic                not_empty;
    logic                push;
    logic                pop;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    assign not_full  = (count != FULL_COUNT);
    assign not_empty = (count != '0);

    // input_ready looks only at registered state and enable, never at
    // output_ready: a full FIFO refuses a push even when it is popping on
    // the same edge. That keeps the downstream ready off the upstream path.
    // The reset term holds ready low for the whole time reset is asserted.
    assign input_ready  = reset & enable & not_full;
    assign output_valid = enable & not_empty;
    assign quiescent    = ~not_empty;

    assign push = input_valid & input_ready;
    assign pop  = output_valid & output_ready;

    // First-word fall-through: the head entry is always presented.
    assign output_tag  = storage[rd_ptr].tag;
    assign output_data = storage[rd_ptr].data;

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage array (not reset; only entries below count are meaningful)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            storage[wr_ptr] <= '{tag: input_tag, data: input_data};
        end
    end

endmodule : interconnect_link_fifo
`default_nettype wire

// File: tb/tb_interconnect_link_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_interconnect_link_fifo
//  Purpose  : Self-checking bench for interconnect_link_fifo. A queue-based
//             reference tracks the buffered words; every falling edge the
//             DUT handshake/status/head outputs are compared against it.
//             Directed scenarios add literal expectations on top.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interconnect_link_fifo;
    import interconnect_link_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = TIA_TAG_WIDTH;
    localparam int WW    = TIA_WORD_WIDTH;

    logic          clock        = 1'b0;
    logic          reset        = 1'b0;
    logic          enable       = 1'b0;
    logic          input_valid  = 1'b0;
    logic [TW-1:0] input_tag    = '0;
    logic [WW-1:0] input_data   = '0;
    logic          output_ready = 1'b0;
    logic          quiescent;
    logic          input_ready;
    logic          output_valid;
    logic [TW-1:0] output_tag;
    logic [WW-1:0] output_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [TW+WW-1:0] model_q[$];   // reference contents, head at index 0
    logic [WW-1:0]    dut_log[$];   // data words the DUT handed downstream
    logic [WW-1:0]    exp_q[$];

    interconnect_link_fifo #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TW),
        .WORD_WIDTH (WW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .quiescent    (quiescent),
        .input_valid  (input_valid),
        .input_tag    (input_tag),
        .input_data   (input_data),
        .input_ready  (input_ready),
        .output_valid (output_valid),
        .output_tag   (output_tag),
        .output_data  (output_data),
        .output_ready (output_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a word is accepted when enabled, offered and there is room;
    // the head leaves when enabled, present and consumed. Both decisions use
    // the occupancy before the edge.
    always @(posedge clock or negedge reset) begin : model_upd
        bit do_push;
        bit do_pop;
        if (!reset) begin
            model_q.delete();
        end else begin
            do_push = enable && input_valid && (model_q.size() < DEPTH);
            do_pop  = enable && output_ready && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({input_tag, input_data});
        end
    end

    // Per-cycle comparison against the reference, away from the active edge.
    always @(negedge clock) begin
        chk("input_ready", input_ready, reset && enable && (model_q.size() < DEPTH));
        chk("output_valid", output_valid, enable && (model_q.size() > 0));
        chk("quiescent", quiescent, model_q.size() == 0);
        if (enable && model_q.size() > 0)
            chk("head_entry", {output_tag, output_data}, model_q[0]);
        if (reset && enable && output_valid && output_ready)
            dut_log.push_back(output_data);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [TW-1:0] t, input logic [WW-1:0] d);
        input_valid = 1'b1;
        input_tag   = t;
        input_data  = d;
        step(1);
        input_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        output_ready = 1'b1;
        input_valid  = 1'b0;
        while (!quiescent && n < bound) begin
            step(1);
            n++;
        end
        chk("drain_done", quiescent, 1'b1);
        output_ready = 1'b0;
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, dut_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
            chk(name, dut_log[i], exp_q[i]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cycles;
        int k;
        logic accepted;

        // --- Reset and idle -------------------------------------------
        input_valid = 1'b1;
        input_data  = 32'h55;
        #12;
        chk("rst_input_ready", input_ready, 1'b0);
        chk("rst_output_valid", output_valid, 1'b0);
        chk("rst_quiescent", quiescent, 1'b1);
        @(posedge clock); #1;
        input_valid = 1'b0;
        enable      = 1'b1;
        reset       = 1'b1;
        step(1);
        chk("ready_after_reset", input_ready, 1'b1);

        // --- Single-word latency --------------------------------------
        dut_log.delete();
        push_word(3'd2, 32'hDEADBEEF);
        chk("single_valid", output_valid, 1'b1);
        chk("single_tag", output_tag, 3'd2);
        chk("single_data", output_data, 32'hDEADBEEF);
        output_ready = 1'b1;
        step(1);
        output_ready = 1'b0;
        chk("single_quiescent", quiescent, 1'b1);
        exp_q = {32'hDEADBEEF};
        check_log("single_log");

        // --- Fill to full, held fifth offer, full with pop -------------
        dut_log.delete();
        for (int i = 0; i < 4; i++) push_word(TW'(i), WW'(32'h10 + i));
        input_valid = 1'b1;
        input_tag   = 3'd4;
        input_data  = 32'h14;
        chk("full_not_ready", input_ready, 1'b0);
        step(2);
        chk("full_held_ready", input_ready, 1'b0);
        chk("full_head", output_data, 32'h10);
        output_ready = 1'b1;
        step(1);    // full: only the pop happens
        chk("full_pop_head", output_data, 32'h11);
        chk("full_pop_ready", input_ready, 1'b1);
        step(1);    // now the held 0x14 goes in alongside a pop
        input_valid = 1'b0;
        drain(20);
        exp_q = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
        check_log("fill_order");

        // --- Streaming across pointer wrap ----------------------------
        dut_log.delete();
        output_ready = 1'b1;
        cycles = 0;
        k = 0;
        while (k < 20 && cycles < 100) begin
            input_valid = 1'b1;
            input_tag   = TW'(k);
            input_data  = WW'(k);
            accepted    = input_ready;
            step(1);
            cycles++;
            if (accepted) k++;
        end
        input_valid = 1'b0;
        while (!quiescent && cycles < 100) begin
            step(1);
            cycles++;
        end
        output_ready = 1'b0;
        chk("stream_cycles", cycles, 21);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(WW'(i));
        check_log("stream_order");

        // --- enable low mid-stream ------------------------------------
        dut_log.delete();
        push_word(3'd0, 32'hA0);
        push_word(3'd1, 32'hA1);
        enable       = 1'b0;
        output_ready = 1'b1;
        input_valid  = 1'b1;
        input_data   = 32'hA2;
        step(3);
        chk("dis_input_ready", input_ready, 1'b0);
        chk("dis_output_valid", output_valid, 1'b0);
        chk("dis_quiescent", quiescent, 1'b0);
        enable = 1'b1;
        drain(10);
        exp_q = {32'hA0, 32'hA1};
        check_log("enable_order");

        // --- Asynchronous reset with words buffered --------------------
        push_word(3'd0, 32'hB0);
        push_word(3'd1, 32'hB1);
        push_word(3'd2, 32'hB2);
        chk("pre_rst_quiescent", quiescent, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_quiescent", quiescent, 1'b1);
        chk("async_rst_valid", output_valid, 1'b0);
        chk("async_rst_ready", input_ready, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        step(1);
        chk("post_rst_ready", input_ready, 1'b1);
        dut_log.delete();
        push_word(3'd5, 32'hC0);
        chk("post_rst_tag", output_tag, 3'd5);
        drain(10);
        exp_q = {32'hC0};
        check_log("post_rst_log");

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_interconnect_link_fifo
`default_nettype wire

// File: doc/interconnect_link_fifo.md
Name: interconnect_link_fifo

Overview:
Elastic buffer inserted on each inter-router interconnect link, directly downstream of a router's output splitter and upstream of the neighbouring router's input combiner.
Decouples the two routers' handshakes and absorbs backpressure so link timing does not chain combinationally across tiles.
First-word-fall-through FIFO of tagged words, with an enable gate and a quiescence flag for the router/PE quiescence tree.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2.
TAG_WIDTH, TIA_TAG_WIDTH, width of the tag field; from the shared interconnect header.
WORD_WIDTH, TIA_WORD_WIDTH, width of the data field; from the shared interconnect header.

Ports:
clock  input  1  single clock, positive-edge triggered.
reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
enable  input  1  active high; when low, no transfers on either side.
quiescent  output  1  high when the FIFO holds no entries.
input_valid  input  1  upstream offers a word.
input_tag  input  TAG_WIDTH  tag of the offered word.
input_data  input  WORD_WIDTH  data of the offered word.
input_ready  output  1  FIFO accepts the offered word this cycle.
output_valid  output  1  head entry is available.
output_tag  output  TAG_WIDTH  tag of the head entry.
output_data  output  WORD_WIDTH  data of the head entry.
output_ready  input  1  downstream consumes the head entry.

Behaviour:
- Reset (reset low, asynchronous): read pointer, write pointer and count go to 0.
  - Outputs during reset: input_ready=0, output_valid=0, quiescent=1; output_tag/output_data are don't-care.
  - Storage contents are not reset.
- Push = enable & input_valid & input_ready. Pop = enable & output_valid & output_ready. Both are evaluated on the rising edge.
- input_ready = enable & (count != DEPTH). It depends only on registered state and enable, never on output_ready. When full there is no push, even if a pop occurs in the same cycle.
- output_valid = enable & (count != 0).
- output_tag and output_data are driven from the entry at the read pointer (first-word fall-through).
- Latency: a word pushed at edge N is visible on output_valid after edge N, so it can be consumed at edge N+1. There is no combinational input-to-output path.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Count has $clog2(DEPTH)+1 bits, so the full value DEPTH is distinguishable from empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Simultaneous push and pop:
  - Allowed whenever 0 < count < DEPTH; count stays constant.
  - When count == 0 only a push is possible, because output_valid=0.
- enable low:
  - Both handshakes are deasserted and state holds.
  - quiescent still reflects count == 0.
- Ordering: strict FIFO; tag and data always travel together.
- Upstream rule: once input_valid is raised it must hold with stable tag/data until accepted. The FIFO obeys the same rule on its output: output_valid and output_tag/output_data never drop or change before a pop (except on reset or enable low).
- quiescent = (count == 0), registered-state only.
- Asserting reset mid-operation discards all buffered words immediately; no partial transfer completes on that edge.

Decomposition:
- Tag/word widths and the link struct come from the shared interconnect header. Add to that header a packed typedef interconnect_entry_t {tag, data}, used for the storage array.
- The FIFO depth default constant TIA_INTERCONNECT_FIFO_DEPTH belongs in the same header.
- No sub-module: pointers, count and the storage array are small enough to live in one module.

Test Plan:
- Reset and idle: hold reset low with input_valid=1 -> input_ready=0, output_valid=0, quiescent=1. Release reset with enable=1 -> input_ready=1 on the next cycle.
- Single-word latency: push tag=2, data=0xDEADBEEF at edge N -> output_valid=1 with those values after edge N. Pop at edge N+1 -> quiescent=1 after it.
- Fill to full (DEPTH=4), output_ready=0: push 0x10..0x13 -> input_ready=0 after the 4th push. A 5th offer (0x14) is held, not lost. Raise output_ready -> words come out in order 0x10, 0x11, 0x12, 0x13, 0x14.
- Streaming with wrap: input_valid and output_ready both held high for 20 words (data 0..19) -> one word per cycle after the first, order preserved across pointer wrap, count never exceeds 1.
- Full with simultaneous pop: count=4, output_ready=1, input_valid=1 -> only the pop happens that edge (count 3). A push is accepted on the next edge.
- enable low mid-stream with count=2: input_ready=0, output_valid=0, state held, quiescent=0. Re-enable -> the remaining 2 words drain in order. Asserting reset with count=3 -> quiescent=1 and output_valid=0 immediately, without waiting for a clock edge.
